// File: rtl/wave_sequencer.sv
// Programmable 8-step waveform sequencer.
// Drives the select and data inputs of an 8:1 mux at a divided tick rate.
module wave_sequencer #(
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [7:0]       pattern_in,
   input  logic             start,
   input  logic             stop,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   output logic [2:0]       sel,
   output logic [7:0]       pattern,
   output logic             running,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      M_UP   = 2'd0,
      M_DOWN = 2'd1,
      M_PING = 2'd2,
      M_ONCE = 2'd3
   } mode_t;

   state_t           state, state_nx;
   mode_t            mode_q, mode_nx;
   logic [DIV_W-1:0] pre, pre_nx;
   logic             dir_down, dir_nx;
   logic [2:0]       sel_nx;
   logic [7:0]       pattern_nx;
   logic             running_nx;
   logic             done_nx;
   logic             wrap_nx;

   logic             tick;
   logic [2:0]       adv_sel;
   logic             adv_dir;
   logic             adv_wrap;
   logic             adv_end;

   // A tick fires when the prescaler reaches the live divider value.
   assign tick = (pre == div);

   // Next step index for the latched mode, assuming a tick happens.
   always_comb begin
      adv_sel  = sel;
      adv_dir  = dir_down;
      adv_wrap = 1'b0;
      adv_end  = 1'b0;
      unique case (mode_q)
         M_UP: begin
            adv_sel  = sel + 3'd1;
            adv_wrap = (sel == 3'd7);
         end
         M_DOWN: begin
            adv_sel  = sel - 3'd1;
            adv_wrap = (sel == 3'd0);
         end
         M_PING: begin
            if (!dir_down) begin
               if (sel == 3'd7) begin
                  adv_sel = 3'd6;
                  adv_dir = 1'b1;
               end else begin
                  adv_sel = sel + 3'd1;
               end
            end else begin
               if (sel == 3'd0) begin
                  adv_sel = 3'd1;
                  adv_dir = 1'b0;
               end else begin
                  adv_sel  = sel - 3'd1;
                  adv_wrap = (sel == 3'd1);
               end
            end
         end
         M_ONCE: begin
            if (sel == 3'd7) begin
               adv_end = 1'b1;
            end else begin
               adv_sel = sel + 3'd1;
            end
         end
      endcase
   end

   // Next-state and next-output logic; stop outranks tick and start.
   always_comb begin
      state_nx   = state;
      mode_nx    = mode_q;
      pre_nx     = pre;
      dir_nx     = dir_down;
      sel_nx     = sel;
      done_nx    = 1'b0;
      wrap_nx    = 1'b0;
      pattern_nx = load ? pattern_in : pattern;
      case (state)
         S_IDLE, S_DONE: begin
            if (start && !stop) begin
               state_nx = S_RUN;
               mode_nx  = mode_t'(mode);
               pre_nx   = '0;
               dir_nx   = 1'b0;
               sel_nx   = (mode == M_DOWN) ? 3'd7 : 3'd0;
            end else if (stop) begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_nx = S_IDLE;
            end else if (tick) begin
               pre_nx = '0;
               if (adv_end) begin
                  state_nx = S_DONE;
                  done_nx  = 1'b1;
               end else begin
                  sel_nx  = adv_sel;
                  dir_nx  = adv_dir;
                  wrap_nx = adv_wrap;
               end
            end else begin
               pre_nx = pre + 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      running_nx = (state_nx == S_RUN);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         mode_q   <= M_UP;
         pre      <= '0;
         dir_down <= 1'b0;
         sel      <= 3'd0;
         pattern  <= 8'h00;
         running  <= 1'b0;
         done     <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         state    <= state_nx;
         mode_q   <= mode_nx;
         pre      <= pre_nx;
         dir_down <= dir_nx;
         sel      <= sel_nx;
         pattern  <= pattern_nx;
         running  <= running_nx;
         done     <= done_nx;
         wrap     <= wrap_nx;
      end
   end

endmodule

// File: tb/tb_wave_sequencer.sv
// Bench for wave_sequencer: directed scenarios plus random stimulus
// checked every cycle against a behavioural model.
module tb_wave_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [7:0] pattern_in = 8'h00;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] div = 4'd0;
   logic [2:0] sel;
   logic [7:0] pattern;
   logic       running;
   logic       done;
   logic       wrap;

   int total = 0;
   int bad = 0;
   bit live = 1'b0;

   // model: state 0=idle 1=run 2=done; ping-pong as position in a 14-step period
   int         m_state = 0;
   int         m_sel = 0;
   int         m_pre = 0;
   int         m_pp = 0;
   int         m_mode = 0;
   logic [7:0] m_pat = 8'h00;
   bit         m_wrap = 1'b0;
   bit         m_done = 1'b0;

   always #5 clk = ~clk;

   wave_sequencer #(.DIV_W(4)) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .pattern_in(pattern_in),
      .start(start),
      .stop(stop),
      .mode(mode),
      .div(div),
      .sel(sel),
      .pattern(pattern),
      .running(running),
      .done(done),
      .wrap(wrap)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      m_wrap = 1'b0;
      m_done = 1'b0;
      if (reset) begin
         m_state = 0;
         m_sel = 0;
         m_pre = 0;
         m_pp = 0;
         m_mode = 0;
         m_pat = 8'h00;
         return;
      end
      if (load) m_pat = pattern_in;
      if (m_state != 1) begin
         if (start && !stop) begin
            m_state = 1;
            m_mode = int'(mode);
            m_pre = 0;
            m_pp = 0;
            m_sel = (m_mode == 1) ? 7 : 0;
         end else if (stop) begin
            m_state = 0;
         end
      end else if (stop) begin
         m_state = 0;
      end else if (m_pre != int'(div)) begin
         m_pre = (m_pre + 1) % 16;
      end else begin
         m_pre = 0;
         case (m_mode)
            0: begin
               m_sel = (m_sel + 1) % 8;
               m_wrap = (m_sel == 0);
            end
            1: begin
               m_sel = (m_sel + 7) % 8;
               m_wrap = (m_sel == 7);
            end
            2: begin
               m_pp = (m_pp + 1) % 14;
               m_sel = (m_pp <= 7) ? m_pp : 14 - m_pp;
               m_wrap = (m_pp == 0);
            end
            default: begin
               if (m_sel == 7) begin
                  m_state = 2;
                  m_done = 1'b1;
               end else begin
                  m_sel = m_sel + 1;
               end
            end
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      reset = 1'b0;
      load = 1'b0;
      start = 1'b0;
      stop = 1'b0;
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (live) begin
         chk("sel", 32'(sel), m_sel);
         chk("pattern", 32'(pattern), 32'(m_pat));
         chk("running", 32'(running), 32'(m_state == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("wrap", 32'(wrap), 32'(m_wrap));
      end
   end

   initial begin
      int pp_exp[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

      // reset state
      reset = 1'b1;
      step();
      live = 1'b1;
      chk("rst_sel", 32'(sel), 0);
      chk("rst_pattern", 32'(pattern), 0);
      chk("rst_running", 32'(running), 0);

      // load B8, run up, div 0
      load = 1'b1;
      pattern_in = 8'hB8;
      step();
      start = 1'b1;
      mode = 2'd0;
      div = 4'd0;
      step();
      chk("up_pattern", 32'(pattern), 32'hB8);
      chk("up_sel0", 32'(sel), 0);
      chk("up_run", 32'(running), 1);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("up_sel", 32'(sel), i % 8);
         chk("up_wrap", 32'(wrap), 32'(i == 8));
      end

      // up, div 3: each step held 4 clocks
      reset = 1'b1;
      step();
      start = 1'b1;
      mode = 2'd0;
      div = 4'd3;
      step();
      for (int k = 0; k < 16; k++) begin
         chk("div3_sel", 32'(sel), k / 4);
         chk("div3_run", 32'(running), 1);
         step();
      end

      // ping-pong, div 0
      reset = 1'b1;
      step();
      start = 1'b1;
      mode = 2'd2;
      div = 4'd0;
      step();
      for (int k = 0; k < 16; k++) begin
         chk("pp_sel", 32'(sel), pp_exp[k]);
         chk("pp_model", 32'(m_sel), pp_exp[k]);
         chk("pp_wrap", 32'(wrap), 32'(k == 14));
         step();
      end

      // one-shot, div 1, then restart from DONE
      reset = 1'b1;
      step();
      start = 1'b1;
      mode = 2'd3;
      div = 4'd1;
      step();
      for (int k = 0; k < 16; k++) begin
         chk("once_sel", 32'(sel), k / 2);
         step();
      end
      chk("once_done", 32'(done), 1);
      chk("once_sel7", 32'(sel), 7);
      chk("once_run", 32'(running), 0);
      chk("once_model_st", 32'(m_state), 2);
      step();
      chk("once_done_fall", 32'(done), 0);
      start = 1'b1;
      step();
      chk("once_restart_sel", 32'(sel), 0);
      chk("once_restart_run", 32'(running), 1);

      // down, stop on a tick at sel 5; start+stop in idle
      reset = 1'b1;
      step();
      start = 1'b1;
      mode = 2'd1;
      div = 4'd0;
      step();
      chk("down_sel7", 32'(sel), 7);
      step();
      step();
      chk("down_sel5", 32'(sel), 5);
      stop = 1'b1;
      step();
      chk("stop_sel", 32'(sel), 5);
      chk("stop_run", 32'(running), 0);
      start = 1'b1;
      stop = 1'b1;
      step();
      chk("ss_run", 32'(running), 0);
      chk("ss_sel", 32'(sel), 5);

      // reset mid-run at sel 4
      load = 1'b1;
      pattern_in = 8'hB8;
      start = 1'b1;
      mode = 2'd0;
      div = 4'd0;
      step();
      for (int k = 0; k < 4; k++) step();
      chk("mid_sel4", 32'(sel), 4);
      reset = 1'b1;
      step();
      chk("mid_sel", 32'(sel), 0);
      chk("mid_pattern", 32'(pattern), 0);
      chk("mid_running", 32'(running), 0);
      chk("mid_done", 32'(done), 0);
      chk("mid_wrap", 32'(wrap), 0);

      // random stimulus
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(99) == 0);
         load = ($urandom_range(7) == 0);
         pattern_in = 8'($urandom);
         start = ($urandom_range(5) == 0);
         stop = ($urandom_range(19) == 0);
         if ($urandom_range(9) == 0) mode = 2'($urandom);
         if ($urandom_range(15) == 0) begin
            if ($urandom_range(3) == 0) div = 4'($urandom);
            else div = 4'($urandom_range(2));
         end
         step();
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 Parameter: DIV_W, 4, width of the tick-divider compare value.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  capture pattern_in into pattern.
REQ-005 pattern_in  input  8  waveform sample pattern, one bit per step.
REQ-006 start  input  1  begin sequencing.
REQ-007 stop  input  1  abort sequencing.
REQ-008 mode  input  2  00 up, 01 down, 10 ping-pong, 11 one-shot up.
REQ-009 div  input  DIV_W  the sequencer SHALL advance sel once every div+1 clocks.
REQ-010 sel  output  3  step index driving the 8:1 mux select.
REQ-011 pattern  output  8  registered pattern driving the 8:1 mux data input.
REQ-012 running  output  1  high while in RUN.
REQ-013 done  output  1  one-cycle pulse on one-shot completion.
REQ-014 wrap  output  1  one-cycle pulse marking a period boundary.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; all outputs SHALL be registered.
REQ-016 load=1 SHALL set pattern<=pattern_in on the next edge in any state, without changing sel, state or prescaler.
REQ-017 In IDLE or DONE, start=1 with stop=0 SHALL enter RUN, latch mode, clear the prescaler, and set sel to 7 for mode 01 and to 0 otherwise, with the ping-pong direction set to up.
REQ-018 In RUN, start SHALL be ignored, with no restart.
REQ-019 In RUN, the prescaler SHALL count 0..div; when prescaler==div, a tick SHALL occur, the prescaler SHALL return to 0, and sel SHALL advance per the latched mode.
REQ-020 With div=0, sel SHALL advance on every clock.
REQ-021 Mode 00: sel SHALL step +1; on 7->0, wrap=1 in the cycle sel shows 0.
REQ-022 Mode 01: sel SHALL step -1; on 0->7, wrap=1 in the cycle sel shows 7.
REQ-023 Mode 10: sel SHALL run 0,1..7,6..0,1..., reversing at 7 and at 0 with no repeated endpoint; wrap=1 in the cycle sel shows 0 after 1->0.
REQ-024 Mode 11: sel SHALL step +1; a tick at sel=7 SHALL enter DONE with sel held at 7, done=1 for one cycle and running=0.
REQ-025 stop=1 in RUN or DONE SHALL enter IDLE on the next edge with sel holding its current value.
REQ-026 stop SHALL take priority over a coincident tick (no advance) and over start.
REQ-027 running SHALL equal (state==RUN) as a registered output.
REQ-028 wrap and done SHALL otherwise be 0.
REQ-029 div and mode changes during RUN: the new div SHALL take effect on the next compare; mode SHALL be used only as latched at start.
REQ-030 A new start from DONE SHALL restart per REQ-017.

Reset
REQ-031 reset=1 SHALL override all inputs and, on the next edge, set state=IDLE, sel=0, pattern=8'h00, running=0, done=0, wrap=0, prescaler=0, direction=up, latched mode=00.
REQ-032 Reset asserted mid-RUN SHALL abort sequencing with no done or wrap pulse.

Verification
REQ-033 load=1 with pattern_in=8'hB8, then start, mode=00, div=0 -> sel 0,1,...,7,0 on consecutive clocks; pattern=8'hB8; wrap high only in the cycle sel returns to 0.
REQ-034 mode=00, div=3 -> each sel value held exactly 4 clocks; running=1 throughout.
REQ-035 mode=10, div=0 -> sel 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; wrap pulses once, at the second 0.
REQ-036 mode=11, div=1 -> sel 0..7, each held 2 clocks; then DONE, sel=7, done pulses once, running falls; a second start restarts from sel=0.
REQ-037 mode=01 with stop asserted on a tick cycle at sel=5 -> IDLE, sel stays 5, no advance; start and stop together in IDLE -> remains IDLE.
REQ-038 reset pulse mid-RUN at sel=4 with pattern=8'hB8 -> next cycle sel=0, pattern=8'h00, running=0, done=0, wrap=0.
